// File: rtl/sw_alloc_lock_pkg.sv
// Shared constants for the switch output allocator.
// Holds the port count, the named port indices, the fixed priority order
// and the lock FSM state encodings used by the allocator and its picker.
package sw_alloc_lock_pkg;

    // Highest port index; request and grant vectors are PORT+1 bits wide.
    localparam int PORT  = 4;
    localparam int NPORT = PORT + 1;

    // Named input port indices.
    localparam int P_NORTH = 0;
    localparam int P_EAST  = 1;
    localparam int P_SOUTH = 2;
    localparam int P_WEST  = 3;
    localparam int P_LOCAL = 4;

    typedef logic [PORT:0] port_vec_t;
    typedef int unsigned   prio_list_t [NPORT];

    // Fixed arbitration order, highest priority first: 4, 3, 0, 1, 2.
    localparam prio_list_t PRIO_ORDER = '{P_LOCAL, P_WEST, P_NORTH, P_EAST, P_SOUTH};

    // Lock FSM state encodings.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // True when at most one bit of a port vector is set.
    function automatic logic is_onehot0(input port_vec_t v);
        return (v & (v - port_vec_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/sw_alloc_lock_prio_pick_fixed.sv
// Combinational fixed-priority picker.
// Walks the candidates in PRIO_ORDER and returns the first one as a one-hot
// winner (all zero when there is no candidate). Skipped inputs are simply
// absent from cand, so priority falls through to the next eligible input.
module prio_pick_fixed
    import sw_alloc_lock_pkg::*;
(
    input  logic [PORT:0] cand,
    output logic [PORT:0] win
);

    // seen[r] is set when any input ranked above position r is a candidate.
    logic [PORT:0] seen;

    assign seen[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_rank
            localparam int IDX = int'(PRIO_ORDER[gi]);

            assign win[IDX] = cand[IDX] & ~seen[gi];

            if (gi < NPORT - 1) begin : g_chain
                assign seen[gi + 1] = seen[gi] | cand[IDX];
            end
        end
    endgenerate

endmodule

// File: rtl/sw_alloc_lock.sv
// Output-port switch allocator with packet lock.
// In IDLE it picks one requesting input (multicast preferred, with a
// starvation override for waiting unicast traffic) and locks the output to
// that input until its tail flit has been transferred downstream.
module sw_alloc_lock
    import sw_alloc_lock_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [PORT:0] u_req,
    input  logic [PORT:0] m_req,
    input  logic [PORT:0] multab_ct,
    input  logic [PORT:0] f_valid,
    input  logic [PORT:0] f_tail,
    input  logic          out_rdy,
    output logic [PORT:0] grt,
    output logic          busy,
    output logic          own_mc
);

    // Counter wide enough to hold STARVE_MAX (at least one bit).
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [0:0]    state_reg,  state_next;
    port_vec_t     owner_reg,  owner_next;
    logic          mc_reg,     mc_next;
    logic [CW-1:0] starve_reg, starve_next;

    logic          starve_hit;
    logic          mc_path;
    port_vec_t     cand;
    port_vec_t     win;
    logic          sel_valid;
    logic          xfer;
    logic          tail_xfer;

    // Candidate set: unicast when starved, else masked multicast if any multicast is asked, else unicast.
    always_comb begin
        starve_hit = (u_req != '0) && (starve_reg == STARVE_LIM);
        mc_path    = 1'b0;
        cand       = u_req;
        if (!starve_hit && (m_req != '0)) begin
            mc_path = 1'b1;
            cand    = m_req & ~multab_ct;
        end
    end

    prio_pick_fixed u_pick (
        .cand (cand),
        .win  (win)
    );

    assign sel_valid = |win;

    // Downstream transfer by the current owner, and whether it carries the tail flit.
    always_comb begin
        xfer      = (state_reg == ST_LOCKED) && out_rdy && (|(owner_reg & f_valid));
        tail_xfer = xfer && (|(owner_reg & f_tail));
    end

    // Next-state logic for the lock FSM, owner, owner class and starvation counter.
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        mc_next     = mc_reg;
        starve_next = starve_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next = ST_LOCKED;
                    owner_next = win;
                    mc_next    = mc_path;
                end
                if (u_req == '0) begin
                    starve_next = '0;
                end else if (sel_valid && mc_path) begin
                    if (starve_reg != STARVE_LIM) begin
                        starve_next = starve_reg + CW'(1);
                    end
                end else if (sel_valid) begin
                    starve_next = '0;
                end
            end
            ST_LOCKED: begin
                // Release only after the tail leaves; no re-arbitration in this cycle.
                if (tail_xfer) begin
                    state_next = ST_IDLE;
                    owner_next = '0;
                    mc_next    = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                owner_next = '0;
                mc_next    = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= '0;
            mc_reg     <= 1'b0;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            mc_reg     <= mc_next;
            starve_reg <= starve_next;
        end
    end

    // Outputs come straight from registers, so reset clears them without waiting for a clock.
    always_comb begin
        busy   = (state_reg == ST_LOCKED);
        grt    = busy ? owner_reg : '0;
        own_mc = busy & mc_reg;
    end

endmodule

// File: tb/tb_sw_alloc_lock.sv
// Self-checking bench for sw_alloc_lock: directed vector table, hand-written
// multi-cycle scenarios, and randomized traffic against a behavioural model.
module tb_sw_alloc_lock;

    localparam int SM = 4;

    logic       clk = 1'b0;
    logic       rst_;
    logic [4:0] u_req, m_req, multab_ct, f_valid, f_tail;
    logic       out_rdy;
    logic [4:0] grt;
    logic       busy, own_mc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sw_alloc_lock #(.STARVE_MAX(SM)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .u_req     (u_req),
        .m_req     (m_req),
        .multab_ct (multab_ct),
        .f_valid   (f_valid),
        .f_tail    (f_tail),
        .out_rdy   (out_rdy),
        .grt       (grt),
        .busy      (busy),
        .own_mc    (own_mc)
    );

    // ---------------- behavioural reference model ----------------
    int order [5] = '{4, 3, 0, 1, 2};
    bit md_locked;
    int md_owner;
    bit md_mc;
    int md_starve;

    function automatic int pick(input logic [4:0] c);
        for (int k = 0; k < 5; k++) begin
            if (c[order[k]]) return order[k];
        end
        return -1;
    endfunction

    task automatic model_reset();
        md_locked = 0;
        md_owner  = 0;
        md_mc     = 0;
        md_starve = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [4:0] c;
        bit         mc;
        int         w;
        if (!md_locked) begin
            if (u_req != 0 && md_starve == SM) begin
                c = u_req; mc = 0;
            end else if (m_req != 0) begin
                c = m_req & ~multab_ct; mc = 1;
            end else begin
                c = u_req; mc = 0;
            end
            w = pick(c);
            if (u_req == 0)         md_starve = 0;
            else if (w >= 0 && mc)  md_starve = (md_starve < SM) ? md_starve + 1 : SM;
            else if (w >= 0)        md_starve = 0;
            if (w >= 0) begin
                md_locked = 1;
                md_owner  = w;
                md_mc     = mc;
            end
        end else if (f_valid[md_owner] && out_rdy && f_tail[md_owner]) begin
            md_locked = 0;
            md_mc     = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [4:0] eg;
        eg = md_locked ? (5'b00001 << md_owner) : 5'b00000;
        chk({tag, "_grt"},    32'(grt),    32'(eg));
        chk({tag, "_busy"},   32'(busy),   32'(md_locked));
        chk({tag, "_own_mc"}, 32'(own_mc), 32'(md_locked && md_mc));
        chk({tag, "_onehot"}, 32'($countones(grt) <= 1), 32'd1);
    endtask

    task automatic drive(input logic [4:0] u, input logic [4:0] m, input logic [4:0] ct,
                         input logic [4:0] fv, input logic [4:0] ft, input logic rdy);
        u_req = u; m_req = m; multab_ct = ct; f_valid = fv; f_tail = ft; out_rdy = rdy;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        drive(5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_grt",    32'(grt),    32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_own_mc", 32'(own_mc), 32'd0);
        model_reset();
        rst_ = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rb;
        logic [4:0] u, m, ct, fv, ft;
        logic       rdy;
        logic [4:0] eg;
        logic       eb, emc;
    } vec_t;

    vec_t tbl [10];

    logic [4:0] gnt_seen [5];
    logic       mc_seen  [5];
    logic [4:0] exp_g4   [5];
    logic       exp_m4   [5];

    initial begin
        int ngr;
        int sent;
        logic [4:0] ft3;

        // Scenario 1: unicast 01001, single-flit packets.
        tbl[0] = '{1'b1, 5'b01001, 5'b00000, 5'b00000, 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b11111, 5'b11111, 1'b1, 5'b01000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00001, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00001, 1'b1, 1'b0};
        // Scenario 2: multicast from 4 and 1, input 4 contention-masked.
        tbl[5] = '{1'b1, 5'b00000, 5'b10010, 5'b10000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 5'b00000, 5'b10010, 5'b10000, 5'b00000, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 5'b00000, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 1'b1, 5'b00010, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 5'b00000, 5'b10000, 5'b00010, 5'b00010, 5'b00010, 1'b1, 5'b00010, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};

        rst_ = 1'b1;
        drive(5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rb) do_reset();
            @(negedge clk);
            drive(tbl[i].u, tbl[i].m, tbl[i].ct, tbl[i].fv, tbl[i].ft, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d_grt", i),    32'(grt),    32'(tbl[i].eg));
            chk($sformatf("vec%0d_busy", i),   32'(busy),   32'(tbl[i].eb));
            chk($sformatf("vec%0d_own_mc", i), 32'(own_mc), 32'(tbl[i].emc));
        end

        // Scenario 3: 4-flit packet on input 3, out_rdy toggling, input 4 waiting.
        do_reset();
        @(negedge clk);
        drive(5'b01000, 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
        chk("s3_idle_grt", 32'(grt), 32'd0);
        sent = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 8)       chk($sformatf("s3_c%0d_grt", c), 32'(grt), 32'(5'b01000));
            else if (c == 9)  chk("s3_release_grt", 32'(grt), 32'd0);
            else              chk("s3_next_grt", 32'(grt), 32'(5'b10000));
            ft3 = (c <= 8 && sent == 3) ? 5'b01000 : 5'b00000;
            drive(5'b11000, 5'b0, 5'b0, 5'b11000, ft3, (c % 2) == 0);
            if (c <= 8 && (c % 2) == 0) sent++;
        end

        // Scenario 4: multicast on 4 and unicast on 2 both continuous.
        do_reset();
        drive(5'b00100, 5'b10000, 5'b0, 5'b11111, 5'b11111, 1'b1);
        exp_g4 = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00100};
        exp_m4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ngr = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (grt != 0 && ngr < 5) begin
                gnt_seen[ngr] = grt;
                mc_seen[ngr]  = own_mc;
                ngr++;
            end
        end
        chk("s4_grant_count", 32'(ngr), 32'd5);
        for (int k = 0; k < ngr; k++) begin
            chk($sformatf("s4_g%0d_grt", k),    32'(gnt_seen[k]), 32'(exp_g4[k]));
            chk($sformatf("s4_g%0d_own_mc", k), 32'(mc_seen[k]),  32'(exp_m4[k]));
        end

        // Scenario 5: asynchronous reset in the middle of a multicast packet.
        do_reset();
        drive(5'b0, 5'b00010, 5'b0, 5'b0, 5'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("s5_locked_grt",    32'(grt),    32'(5'b00010));
        chk("s5_locked_own_mc", 32'(own_mc), 32'd1);
        @(posedge clk);
        #3 rst_ = 1'b0;
        #1;
        chk("s5_async_grt",    32'(grt),    32'd0);
        chk("s5_async_busy",   32'(busy),   32'd0);
        chk("s5_async_own_mc", 32'(own_mc), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        chk("s5_regrant_grt",    32'(grt),    32'(5'b00010));
        chk("s5_regrant_own_mc", 32'(own_mc), 32'd1);

        // Randomized traffic: general mix, then unicast pressure under heavy multicast.
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            for (int c = 0; c < 2500; c++) begin
                logic [4:0] ru, rm, rct, rfv, rft;
                @(negedge clk);
                check_model($sformatf("rnd%0d_c%0d", phase, c));
                ru  = 5'($urandom) & 5'($urandom);
                rm  = ($urandom_range(0, 2) == 0) ? (5'($urandom) & 5'($urandom)) : 5'b0;
                rct = 5'($urandom) & 5'($urandom) & 5'($urandom);
                if (phase == 1) begin
                    ru  = ru | (5'b00001 << $urandom_range(0, 4));
                    rm  = ($urandom_range(0, 7) != 0) ? (5'($urandom) | 5'b00001) : 5'b0;
                    rct = rct & 5'b11110;
                end
                rfv = 5'($urandom) | 5'($urandom);
                rft = 5'($urandom) & (5'($urandom) | 5'($urandom));
                drive(ru, rm, rct, rfv, rft, $urandom_range(0, 9) < 7);
                model_step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_alloc_lock.md
SW_ALLOC_LOCK -- requirements
Module: sw_alloc_lock

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, giving the consecutive multicast wins tolerated while a unicast request waits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port u_req, input, `PORT+1 bits: unicast request per input port for this output.
REQ-005 SHALL have port m_req, input, `PORT+1 bits: multicast request per input port.
REQ-006 SHALL have port multab_ct, input, `PORT+1 bits: multicast/absorb contention per input port.
REQ-007 SHALL have port f_valid, input, `PORT+1 bits: flit present at the head of each input buffer.
REQ-008 SHALL have port f_tail, input, `PORT+1 bits: the head flit of that input is a tail flit.
REQ-009 SHALL have port out_rdy, input, 1 bit: downstream credit available this cycle.
REQ-010 SHALL have port grt, output, `PORT+1 bits: one-hot or zero grant to the owning input.
REQ-011 SHALL have port busy, output, 1 bit: the output is locked to a packet.
REQ-012 SHALL have port own_mc, output, 1 bit: the current owner was granted as multicast.

Function
REQ-013 SHALL implement states IDLE and LOCKED.
REQ-014 In IDLE, candidates SHALL be multicast requests m_req & ~multab_ct when m_req is nonzero, otherwise u_req.
REQ-015 Priority order SHALL be input 4, 3, 0, 1, 2. A contention-masked multicast input is skipped and priority passes to the next eligible input.
REQ-016 Starvation override: when u_req is nonzero and starve_cnt equals STARVE_MAX, candidates SHALL be u_req regardless of m_req.
REQ-017 In IDLE, when any candidate exists, the block SHALL register the winner as owner, set own_mc, and move to LOCKED on the next edge. This gives 1-cycle grant latency. out_rdy does not gate selection.
REQ-018 In IDLE, grt SHALL be zero and busy SHALL be 0.
REQ-019 In LOCKED, grt SHALL equal the one-hot owner and busy SHALL be 1.
REQ-020 A transfer occurs in a cycle where grt[i], f_valid[i] and out_rdy are all 1. A transfer with f_tail[i] SHALL return to IDLE on the next edge.
REQ-021 A transfer without tail, or a cycle with no transfer, SHALL hold LOCKED and the owner unchanged, even if the owner's request bits or multab_ct change.
REQ-022 No re-arbitration SHALL occur in the cycle that releases the lock; the next grant appears at the earliest 2 cycles after the tail transfer.
REQ-023 starve_cnt SHALL:
  - increment, saturating at STARVE_MAX, on each IDLE multicast selection made while u_req is nonzero;
  - clear on any unicast selection;
  - clear on any IDLE cycle where u_req is zero.
REQ-024 own_mc SHALL be 1 only in LOCKED when the owner was chosen from the multicast candidates.
REQ-025 grt SHALL never have more than one bit set.

Reset
REQ-026 Asserting rst_ SHALL immediately force IDLE, owner=0, grt=0, busy=0, own_mc=0, starve_cnt=0, including mid-packet; the interrupted packet is abandoned.
REQ-027 After deassertion, the first grant SHALL appear no earlier than 1 cycle after the first qualifying request.

Structure
REQ-028 `PORT and the port index constants (north/east/south/west/local) SHALL come from the shared define.h; the priority-order list SHALL be a constant in it.
REQ-029 The combinational priority pick SHALL be a sub-module named prio_pick_fixed (inputs cand, output one-hot win). It is instantiated once.
REQ-030 The state register, owner register and starve_cnt SHALL live in sw_alloc_lock.

Verification
REQ-031 Scenario 1: u_req=5'b01001, single-flit packet, f_valid and f_tail both 1, out_rdy=1 -> grt=5'b01000 one cycle later, IDLE the following cycle, grt=5'b00001 two cycles after that.
REQ-032 Scenario 2: m_req=5'b10000, multab_ct=5'b10000, m_req[1] also 1 -> owner is input 1, own_mc=1.
REQ-033 Scenario 3: 4-flit packet on input 3 with out_rdy toggling 1,0,1,0,... -> grt holds 5'b01000 for 8 cycles. Input 4 requesting throughout is not granted until after the tail.
REQ-034 Scenario 4: m_req[4] continuous and u_req[2] continuous, STARVE_MAX=4 -> four multicast packets to input 4, then one unicast grant to input 2.
REQ-035 Scenario 5: rst_ pulsed low mid-packet while LOCKED -> grt=0 and busy=0 asynchronously; re-arbitration follows normal rules after release.
